// File: rtl/pipelined_sat_adder.sv
// Pipelined N-bit adder with valid/ready handshake. The carry chain is cut into SEG-bit
// segments, one per register stage; wrap/usat/ssat is applied in the final stage.
module pipelined_sat_adder #(
    parameter int N   = 8,
    parameter int SEG = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic [1:0]   mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);
    localparam int STAGES = N / SEG;
    localparam logic [1:0] MODE_USAT = 2'b01;
    localparam logic [1:0] MODE_SSAT = 2'b10;
    localparam logic [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] SMAX = ~SMIN;

    logic         advance;
    logic         out_valid_reg;
    logic [N-1:0] sum_reg;
    logic         cout_reg;
    logic         ovf_reg;

    // Whole pipeline moves together: it can shift whenever the output slot is free or draining.
    assign advance   = out_ready || !out_valid_reg;
    assign in_ready  = advance;
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;

    for (genvar gi = 0; gi < STAGES; gi++) begin : stg
        // RW: operand bits still to be added (current segment at the bottom); LW: result bits known.
        localparam int RW = N - gi * SEG;
        localparam int LW = (gi + 1) * SEG;

        logic [RW-1:0]  a_in;
        logic [RW-1:0]  b_in;
        logic           c_in;
        logic           v_in;
        logic [1:0]     m_in;
        logic [SEG-1:0] seg_sum;
        logic           seg_carry;
        logic [LW-1:0]  s_next;

        if (gi == 0) begin : src
            assign a_in   = a;
            assign b_in   = b;
            assign c_in   = cin;
            assign v_in   = in_valid;
            assign m_in   = mode;
            assign s_next = seg_sum;
        end else begin : src
            assign a_in   = stg[gi-1].fwd.a_reg;
            assign b_in   = stg[gi-1].fwd.b_reg;
            assign c_in   = stg[gi-1].fwd.c_reg;
            assign v_in   = stg[gi-1].fwd.v_reg;
            assign m_in   = stg[gi-1].fwd.m_reg;
            assign s_next = {seg_sum, stg[gi-1].fwd.s_reg};
        end

        assign {seg_carry, seg_sum} = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]}
                                    + {{SEG{1'b0}}, c_in};

        if (gi < STAGES - 1) begin : fwd
            logic [RW-SEG-1:0] a_reg;
            logic [RW-SEG-1:0] b_reg;
            logic [LW-1:0]     s_reg;
            logic              c_reg;
            logic              v_reg;
            logic [1:0]        m_reg;

            // Bubbles shift too; their payload is simply ignored downstream.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_reg <= '0;
                    b_reg <= '0;
                    s_reg <= '0;
                    c_reg <= 1'b0;
                    v_reg <= 1'b0;
                    m_reg <= 2'b00;
                end else if (advance) begin
                    a_reg <= a_in[RW-1:SEG];
                    b_reg <= b_in[RW-1:SEG];
                    s_reg <= s_next;
                    c_reg <= seg_carry;
                    v_reg <= v_in;
                    m_reg <= m_in;
                end
            end
        end else begin : fin
            logic         sign_a;
            logic         sign_b;
            logic         raw_ovf;
            logic [N-1:0] sat_sum;

            assign sign_a  = a_in[SEG-1];
            assign sign_b  = b_in[SEG-1];
            assign raw_ovf = (sign_a == sign_b) && (s_next[N-1] != sign_a);

            always_comb begin
                sat_sum = s_next;
                case (m_in)
                    MODE_USAT: if (seg_carry) sat_sum = '1;
                    MODE_SSAT: if (raw_ovf) sat_sum = sign_a ? SMIN : SMAX;
                    default:   sat_sum = s_next;
                endcase
            end

            // Result fields only load on a real beat so an empty pipeline keeps the last answer.
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_reg <= 1'b0;
                    sum_reg       <= '0;
                    cout_reg      <= 1'b0;
                    ovf_reg       <= 1'b0;
                end else if (advance) begin
                    out_valid_reg <= v_in;
                    if (v_in) begin
                        sum_reg  <= sat_sum;
                        cout_reg <= seg_carry;
                        ovf_reg  <= raw_ovf;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_sat_adder.sv
// Bench for pipelined_sat_adder: directed cases on N=8/SEG=4 plus randomized sweeps on
// three configurations against an arithmetic reference model.
module tb_pipelined_sat_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic mark_done();
        done_cnt++;
    endtask

    // Reference: plain integer arithmetic. Returns {ovf, cout, sum[15:0]}.
    function automatic logic [31:0] ref_pack(int n, logic [15:0] a, logic [15:0] b,
                                             logic cin, logic [1:0] mode);
        longint lim  = longint'(1) << n;
        longint ua   = longint'(a);
        longint ub   = longint'(b);
        longint full = ua + ub + longint'(cin);
        longint raw  = full % lim;
        longint sa   = (ua >= lim / 2) ? ua - lim : ua;
        longint sb   = (ub >= lim / 2) ? ub - lim : ub;
        longint ts   = sa + sb + longint'(cin);
        logic   co   = (full >= lim);
        logic   of   = (ts >= lim / 2) || (ts < -(lim / 2));
        longint res  = raw;
        logic [63:0] rv;
        if (mode == 2'b01 && co) res = lim - 1;
        if (mode == 2'b10 && of) res = (ts < 0) ? lim / 2 : lim / 2 - 1;
        rv = 64'(res);
        return {14'b0, of, co, rv[15:0]};
    endfunction

    // ---------------- directed instance ----------------
    logic       rst_d = 1'b1;
    logic       d_iv, d_ir, d_ov, d_or, d_ci, d_co, d_of;
    logic [7:0] d_a, d_b, d_sum;
    logic [1:0] d_md;
    logic [31:0] dq[$];

    pipelined_sat_adder #(.N(8), .SEG(4)) dut (
        .clk(clk), .rst(rst_d), .in_valid(d_iv), .in_ready(d_ir), .a(d_a), .b(d_b),
        .cin(d_ci), .mode(d_md), .out_valid(d_ov), .out_ready(d_or), .sum(d_sum),
        .cout(d_co), .ovf(d_of)
    );

    task automatic dcycle(logic iv, logic orr, logic [7:0] a, logic [7:0] b, logic ci,
                          logic [1:0] md, string tag);
        @(negedge clk);
        d_iv = iv; d_or = orr; d_a = a; d_b = b; d_ci = ci; d_md = md;
        #1;
        check({tag, "_ready"}, d_ir, d_or || !d_ov);
        if (d_ov) begin
            if (dq.size() == 0) check({tag, "_extra"}, 1, 0);
            else check(tag, {14'b0, d_of, d_co, 8'b0, d_sum}, dq[0]);
            if (d_or && dq.size() > 0) void'(dq.pop_front());
        end
        if (d_iv && d_ir) dq.push_back(ref_pack(8, {8'b0, a}, {8'b0, b}, ci, md));
    endtask

    task automatic run_one(logic [7:0] a, logic [7:0] b, logic ci, logic [1:0] md,
                           logic [7:0] es, logic ec, logic eo, string tag);
        @(negedge clk);
        d_iv = 1'b1; d_or = 1'b1; d_a = a; d_b = b; d_ci = ci; d_md = md;
        #1 check({tag, "_accept"}, d_ir, 1);
        @(negedge clk);
        d_iv = 1'b0;
        check({tag, "_early"}, d_ov, 0);
        @(negedge clk);
        check({tag, "_valid"}, d_ov, 1);
        check(tag, {d_of, d_co, d_sum}, {eo, ec, es});
    endtask

    initial begin
        d_iv = 0; d_or = 0; d_a = 0; d_b = 0; d_ci = 0; d_md = 0;
        repeat (3) @(negedge clk);
        rst_d = 1'b0;
        #1;
        check("rst_valid", d_ov, 0);
        check("rst_sum", d_sum, 0);
        check("rst_cout", d_co, 0);
        check("rst_ovf", d_of, 0);
        check("rst_ready", d_ir, 1);

        run_one(8'd90,  8'd18,  1'b0, 2'b00, 8'd108, 1'b0, 1'b0, "basic");
        run_one(8'h0F,  8'h01,  1'b0, 2'b00, 8'h10,  1'b0, 1'b0, "seg_carry");
        run_one(8'hFF,  8'h00,  1'b1, 2'b00, 8'h00,  1'b1, 1'b0, "cin_ripple");
        run_one(8'd200, 8'd100, 1'b0, 2'b00, 8'd44,  1'b1, 1'b0, "wrap");
        run_one(8'd200, 8'd100, 1'b0, 2'b01, 8'd255, 1'b1, 1'b0, "usat");
        run_one(8'd100, 8'd100, 1'b0, 2'b10, 8'd127, 1'b0, 1'b1, "ssat_pos");
        run_one(8'h9C,  8'h9C,  1'b0, 2'b10, 8'h80,  1'b1, 1'b1, "ssat_neg");
        run_one(8'h9C,  8'h9C,  1'b0, 2'b00, 8'h38,  1'b1, 1'b1, "wrap_neg");
        run_one(8'h9C,  8'h9C,  1'b0, 2'b11, 8'h38,  1'b1, 1'b1, "mode3");

        @(negedge clk);
        #1;
        check("empty_valid", d_ov, 0);
        check("empty_hold", {d_co, d_sum}, {1'b1, 8'h38});

        for (int k = 0; k < 11; k++) begin
            dcycle(k < 8, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom), "stream");
            if (k >= 2 && k <= 9) check("stream_gap", d_ov, 1);
        end
        check("stream_drain", dq.size(), 0);

        for (int k = 0; k < 6; k++)
            dcycle(1'b1, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom), "bp_stall");
        check("bp_accepted", dq.size(), 2);
        for (int k = 0; k < 4; k++)
            dcycle(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 2'b00, "bp_release");
        check("bp_drain", dq.size(), 0);

        dcycle(1'b1, 1'b0, 8'h11, 8'h22, 1'b0, 2'b00, "rst_fill");
        dcycle(1'b1, 1'b0, 8'h33, 8'h44, 1'b0, 2'b00, "rst_fill");
        @(negedge clk);
        d_iv = 1'b0;
        rst_d = 1'b1;
        @(negedge clk);
        rst_d = 1'b0;
        #1;
        check("midrst_valid", d_ov, 0);
        check("midrst_sum", {d_of, d_co, d_sum}, 0);
        dq.delete();
        for (int k = 0; k < 3; k++)
            dcycle(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 2'b00, "midrst_ghost");
        run_one(8'h12, 8'h34, 1'b1, 2'b00, 8'h47, 1'b0, 1'b0, "after_rst");
        mark_done();
    end

    // ---------------- randomized sweeps ----------------
    logic rst_r = 1'b1;
    initial begin
        repeat (3) @(negedge clk);
        rst_r = 1'b0;
    end

    localparam int BEATS = 10000;

    for (genvar gi = 0; gi < 3; gi++) begin : sw
        localparam int NN = (gi == 1) ? 16 : 8;
        localparam int SS = (gi == 2) ? 8 : 4;
        logic          s_iv, s_ir, s_ov, s_or, s_ci, s_co, s_of;
        logic [NN-1:0] s_a, s_b, s_sum;
        logic [1:0]    s_md;
        logic [31:0]   q[$];

        pipelined_sat_adder #(.N(NN), .SEG(SS)) dut (
            .clk(clk), .rst(rst_r), .in_valid(s_iv), .in_ready(s_ir), .a(s_a), .b(s_b),
            .cin(s_ci), .mode(s_md), .out_valid(s_ov), .out_ready(s_or), .sum(s_sum),
            .cout(s_co), .ovf(s_of)
        );

        initial begin
            int    pushed = 0;
            int    cyc = 0;
            string tg;
            tg = $sformatf("sweep_n%0d_seg%0d", NN, SS);
            s_iv = 0; s_or = 0; s_a = 0; s_b = 0; s_ci = 0; s_md = 0;
            while (rst_r) @(negedge clk);
            while ((pushed < BEATS || q.size() > 0) && cyc < 60000) begin
                @(negedge clk);
                cyc++;
                s_iv = (pushed < BEATS) && ($urandom_range(0, 3) != 0);
                s_or = ($urandom_range(0, 3) != 0);
                s_a  = NN'($urandom);
                s_b  = NN'($urandom);
                s_ci = 1'($urandom);
                s_md = 2'($urandom);
                #1;
                if (s_ov && s_or) begin
                    if (q.size() == 0) check({tg, "_extra"}, 1, 0);
                    else check(tg, {14'b0, s_of, s_co, 16'(s_sum)}, q.pop_front());
                end
                if (s_iv && s_ir) begin
                    q.push_back(ref_pack(NN, 16'(s_a), 16'(s_b), s_ci, s_md));
                    pushed++;
                end
            end
            check({tg, "_beats"}, pushed, BEATS);
            check({tg, "_drain"}, q.size(), 0);
            mark_done();
        end
    end

    initial begin
        for (int i = 0; i < 80000 && done_cnt < 4; i++) @(negedge clk);
        check("all_done", done_cnt, 4);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
